irq_gen: RTL and testbench

IRQ_GEN -- requirements
Module: irq_gen

---
 rtl/irq_gen_if.sv | 21 ++
 rtl/irq_gen.sv | 112 +++++++++++
 tb/tb_irq_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_gen_if.sv
// Interrupt handshake between the coalescing generator and the PCIe core cfg port.
interface irq_gen_if;
  logic       cfg_interrupt_n;
  logic       cfg_interrupt_rdy_n;
  logic [7:0] cfg_interrupt_di;
  logic       cfg_interrupt_assert_n;

  modport master (
    output cfg_interrupt_n,
    output cfg_interrupt_di,
    output cfg_interrupt_assert_n,
    input  cfg_interrupt_rdy_n
  );

  modport slave (
    input  cfg_interrupt_n,
    input  cfg_interrupt_di,
    input  cfg_interrupt_assert_n,
    output cfg_interrupt_rdy_n
  );
endinterface

// File: rtl/irq_gen.sv
// MSI interrupt coalescer: counts DMA completion events and raises one interrupt
// per timer window or event-threshold burst, holding the request until acknowledged.
module irq_gen #(
  parameter int unsigned COAL_CYCLES = 250,
  parameter int unsigned COAL_EVENTS = 16
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic        interrupts_enabled,
  input  logic        irq_event,
  irq_gen_if.master   cfg,
  output logic [15:0] pending,
  output logic [31:0] irq_count
);

  localparam logic [15:0] TIMER_LOAD = 16'(COAL_CYCLES - 1);
  localparam logic [15:0] EVENT_THR  = 16'(COAL_EVENTS);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    TIMING  = 4'b0010,
    REQ     = 4'b0100,
    HOLDOFF = 4'b1000
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] pending_q, pending_d;
  logic [31:0] irq_count_q, irq_count_d;
  logic        cfg_int_n_q, cfg_int_n_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // State, timer, counters and the registered request line.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= 16'd0;
      pending_q   <= 16'd0;
      irq_count_q <= 32'd0;
      cfg_int_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      irq_count_q <= irq_count_d;
      cfg_int_n_q <= cfg_int_n_d;
    end
  end

  // Next-state and counter update; events are counted in every state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    irq_count_d = irq_count_q;
    pending_d   = irq_event ? sat_inc16(pending_q) : pending_q;

    case (state_q)
      IDLE: begin
        if (interrupts_enabled && (pending_q != 16'd0)) begin
          state_d = TIMING;
          timer_d = TIMER_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      TIMING: begin
        if (!interrupts_enabled) begin
          state_d = IDLE;
          timer_d = 16'd0;
        end else if ((timer_q == 16'd0) || (pending_q >= EVENT_THR)) begin
          state_d = REQ;
          timer_d = 16'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      REQ: begin
        // Ack covers everything counted so far; only a same-edge event survives.
        if (!cfg.cfg_interrupt_rdy_n) begin
          state_d     = HOLDOFF;
          irq_count_d = irq_count_q + 32'd1;
          pending_d   = {15'd0, irq_event};
        end else begin
          state_d = REQ;
        end
      end
      HOLDOFF: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = 16'd0;
      end
    endcase

    cfg_int_n_d = (state_d != REQ);
  end

  assign cfg.cfg_interrupt_n        = cfg_int_n_q;
  assign cfg.cfg_interrupt_di       = 8'h00;
  assign cfg.cfg_interrupt_assert_n = 1'b1;
  assign pending                    = pending_q;
  assign irq_count                  = irq_count_q;

endmodule

// File: tb/tb_irq_gen.sv
// Directed bench for irq_gen with default COAL_CYCLES=250, COAL_EVENTS=16.
module tb_irq_gen;

  logic        trn_clk = 1'b0;
  logic        reset_n;
  logic        interrupts_enabled;
  logic        irq_event;
  logic [15:0] pending;
  logic [31:0] irq_count;
  int          checks = 0;
  int          errors = 0;

  irq_gen_if cfg_if ();

  irq_gen #(.COAL_CYCLES(250), .COAL_EVENTS(16)) dut (
    .trn_clk            (trn_clk),
    .reset_n            (reset_n),
    .interrupts_enabled (interrupts_enabled),
    .irq_event          (irq_event),
    .cfg                (cfg_if),
    .pending            (pending),
    .irq_count          (irq_count)
  );

  always #5 trn_clk = ~trn_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic pulse_event();
    irq_event = 1'b1;
    tick();
    irq_event = 1'b0;
  endtask

  // Ticks until the request goes low; n = ticks taken, or -1 if the bound expires.
  task automatic wait_req(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (cfg_if.cfg_interrupt_n == 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  // Runs for a window and reports whether the request line ever went low.
  task automatic watch_quiet(input int cyc, output logic seen_low);
    seen_low = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (cfg_if.cfg_interrupt_n == 1'b0) seen_low = 1'b1;
    end
  endtask

  task automatic ack(input logic ev);
    cfg_if.cfg_interrupt_rdy_n = 1'b0;
    irq_event = ev;
    tick();
    cfg_if.cfg_interrupt_rdy_n = 1'b1;
    irq_event = 1'b0;
  endtask

  initial begin
    int   n;
    logic seen;

    reset_n = 1'b0;
    interrupts_enabled = 1'b0;
    irq_event = 1'b0;
    cfg_if.cfg_interrupt_rdy_n = 1'b1;
    repeat (3) tick();
    chk("rst_cfg_n", 32'(cfg_if.cfg_interrupt_n), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_count", irq_count, 32'd0);
    chk("const_di", 32'(cfg_if.cfg_interrupt_di), 32'd0);
    chk("const_assert_n", 32'(cfg_if.cfg_interrupt_assert_n), 32'd1);
    reset_n = 1'b1;
    tick();
    tick();
    interrupts_enabled = 1'b1;

    // Single event: request low 251 cycles after the event edge.
    pulse_event();
    chk("t1_pending", 32'(pending), 32'd1);
    wait_req(400, n);
    chk("t1_latency", 32'(n), 32'd251);
    tick();
    tick();
    chk("t1_held", 32'(cfg_if.cfg_interrupt_n), 32'd0);
    ack(1'b0);
    chk("t1_release", 32'(cfg_if.cfg_interrupt_n), 32'd1);
    chk("t1_count", irq_count, 32'd1);
    chk("t1_pending0", 32'(pending), 32'd0);
    watch_quiet(5, seen);
    chk("t1_quiet", 32'(seen), 32'd0);

    // Threshold: 16 back-to-back events, request one cycle after pending hits 16.
    irq_event = 1'b1;
    repeat (16) tick();
    irq_event = 1'b0;
    chk("t2_pending16", 32'(pending), 32'd16);
    chk("t2_not_yet", 32'(cfg_if.cfg_interrupt_n), 32'd1);
    tick();
    chk("t2_req", 32'(cfg_if.cfg_interrupt_n), 32'd0);
    ack(1'b0);
    chk("t2_count", irq_count, 32'd2);
    chk("t2_pending0", 32'(pending), 32'd0);
    tick();

    // Late arrivals; rdy_n held low in TIMING must be ignored.
    pulse_event();
    cfg_if.cfg_interrupt_rdy_n = 1'b0;
    irq_event = 1'b1;
    repeat (5) tick();
    irq_event = 1'b0;
    cfg_if.cfg_interrupt_rdy_n = 1'b1;
    chk("t3_pending6", 32'(pending), 32'd6);
    chk("t3_rdy_ignored", irq_count, 32'd2);
    wait_req(400, n);
    chk("t3_latency", 32'(n), 32'd246);
    irq_event = 1'b1;
    repeat (3) tick();
    irq_event = 1'b0;
    chk("t3_pending9", 32'(pending), 32'd9);
    chk("t3_still_req", 32'(cfg_if.cfg_interrupt_n), 32'd0);
    ack(1'b0);
    chk("t3_count", irq_count, 32'd3);
    chk("t3_pending0", 32'(pending), 32'd0);
    watch_quiet(300, seen);
    chk("t3_one_irq", 32'(seen), 32'd0);

    // Event on the acknowledge edge carries into a second interrupt.
    pulse_event();
    wait_req(400, n);
    chk("t4_latency", 32'(n), 32'd251);
    ack(1'b1);
    chk("t4_pending1", 32'(pending), 32'd1);
    chk("t4_count", irq_count, 32'd4);
    wait_req(400, n);
    chk("t4_second", 32'(n), 32'd252);
    ack(1'b0);
    chk("t4_count2", irq_count, 32'd5);
    chk("t4_pending0", 32'(pending), 32'd0);
    tick();

    // Disable in TIMING, re-enable gives a full run, disable in REQ holds the request.
    pulse_event();
    repeat (10) tick();
    interrupts_enabled = 1'b0;
    tick();
    watch_quiet(300, seen);
    chk("t5_no_irq", 32'(seen), 32'd0);
    chk("t5_pending_kept", 32'(pending), 32'd1);
    interrupts_enabled = 1'b1;
    wait_req(400, n);
    chk("t5_full_run", 32'(n), 32'd251);
    interrupts_enabled = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cfg_if.cfg_interrupt_n == 1'b1) seen = 1'b1;
    end
    chk("t5_req_held", 32'(seen), 32'd0);
    ack(1'b0);
    chk("t5_count", irq_count, 32'd6);
    chk("t5_pending0", 32'(pending), 32'd0);
    interrupts_enabled = 1'b1;
    tick();

    // Reset while requesting drops everything without a clock edge.
    pulse_event();
    wait_req(400, n);
    chk("t6_latency", 32'(n), 32'd251);
    reset_n = 1'b0;
    #2;
    chk("t6_rst_cfg_n", 32'(cfg_if.cfg_interrupt_n), 32'd1);
    chk("t6_rst_pending", 32'(pending), 32'd0);
    chk("t6_rst_count", irq_count, 32'd0);
    #1;
    reset_n = 1'b1;
    watch_quiet(300, seen);
    chk("t6_quiet", 32'(seen), 32'd0);
    pulse_event();
    wait_req(400, n);
    chk("t6_new_irq", 32'(n), 32'd251);
    ack(1'b0);
    chk("t6_count", irq_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
